bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

Parametrised BCD countdown timer for the microwave controller, successor to the fixed 4-bit `timer`. Digits are keyed in one at a time from the keypad encoder and shifted in on the right. On `start` the block counts down in MM:SS style: the seconds-tens digit wraps 0→5 and every other digit wraps 0→9. An internal prescaler derives the one-second tick from `clock`. The block pulses `done` when the count reaches zero; its outputs feed the display driver and the magnetron/door control logic.

## Interface
- `NUM_DIGITS`, default 4: number of BCD digits. Must be ≥2. Digit 0 is seconds-units and digit 1 is seconds-tens.
- `TICK_DIV`, default 100: `clock` cycles per count decrement. Must be ≥1.
- `clock` in 1: single clock; all state changes on its rising edge.
- `clear` in 1: synchronous, active-high reset; dominates every other input.
- `data_in` in 4: BCD digit from the keypad encoder.
- `loadn` in 1: active-low digit strobe; each sampled-low cycle shifts in one digit.
- `start` in 1: start request, sampled each cycle.
- `enable` in 1: run gate; low pauses the countdown.
- `digits` out 4*NUM_DIGITS: current count, digit i at bits [4i+3:4i].
- `zero` out 1: high when every digit is 0.
- `running` out 1: high in state RUN.
- `done` out 1: one-cycle pulse on reaching zero.

## Operation
- States: IDLE and RUN.
- Reset (`clear`=1 at an edge) sets: state IDLE, `digits`=0, prescaler=0, `zero`=1, `running`=0, `done`=0.
- IDLE, `loadn`=0: `digits` ← {`digits`[4*NUM_DIGITS-5:0], d}. d = `data_in`, clamped to 9 if above 9. The MS digit is discarded.
- IDLE, `loadn`=1, `start`=1, `zero`=0: go to RUN and set prescaler to 0.
- IDLE, `start` with `zero`=1: ignored.
- IDLE, `loadn`=0 and `start`=1 in the same cycle: shift only; `start` is ignored.
- RUN: `loadn` and `start` are ignored.
- RUN, `enable`=0: prescaler and digits hold.
- RUN, `enable`=1, prescaler < TICK_DIV-1: prescaler increments.
- RUN, `enable`=1, prescaler = TICK_DIV-1: prescaler ← 0 and the count decrements by one.
- Decrement rule: digit 0 always decrements. A digit at 0 borrows from the next digit up and reloads: 5 for digit 1, 9 for all others.
- Digit 1 loaded above 5 (e.g. 7) counts down normally from that value. Only reloads are limited to 5.
- If a decrement makes every digit 0: go to IDLE, `done`=1 for that cycle, `running`=0.
- `zero` and `running` are registered, updated on the same edge as `digits`.

## Timing
- Digit shift: visible on the edge where `loadn`=0 is sampled.
- Start: `running` rises on the edge sampling `start`.
- First decrement: the TICK_DIV-th edge after the start edge, counting only `enable`=1 edges. Later decrements follow every TICK_DIV enabled edges.
- Pause is exact: the prescaler is not reset. After resume, the remaining cycles to the next decrement equal those left at pause.
- `done`: high exactly one cycle, on the same edge that `digits` become 0, `zero` rises and `running` falls.
- `clear` mid-RUN: next edge gives reset values. No `done` pulse.
- TICK_DIV=1: one decrement on every enabled edge.

## Structure
- Package `timer_pkg`:
  - `state_t` enum {IDLE, RUN}.
  - `DIGIT_W`=4.
  - `SEC_TENS_IDX`=1.
  - `RELOAD_SEC_TENS`=5.
  - `RELOAD_DEFAULT`=9.
- Sub-module `bcd_down_digit`:
  - Parameter `RELOAD`.
  - Inputs `dec`, `load`, `load_val`.
  - Outputs `q` and combinational `borrow_out`, where `borrow_out` = `dec` & (`q`==0).
  - Top level instantiates NUM_DIGITS copies with the borrow chained.
  - Top level holds the prescaler, FSM, shift logic and `zero`/`done`.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=2.
- **Reset:** hold `clear`=1 with `loadn`=0, `start`=1 → `digits`=16'h0000, `zero`=1, `running`=0, `done`=0.
- **Load and clamp:** shift 1, 0, 4'hC with `loadn` low for 3 cycles → `digits`=16'h0109.
- **Borrow and reload:** load 1,0,0 and start → 2 enabled edges later `digits`=16'h0059. 2 edges after that, 16'h0058.
- **Done:** load 2 and start → `done` high one cycle on the 4th edge after start, `digits`=0, `zero`=1, `running`=0. A `start` on the next cycle is ignored.
- **Pause:** run from 16'h0030, drop `enable` one edge after start for 10 cycles → `digits` frozen. First decrement occurs one enabled edge after resume.
- **Clear mid-run:** assert `clear` while running from 16'h0130 with `loadn`=0 → next edge `digits`=0, `running`=0, no `done`.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned SEC_TENS_IDX    = 1;
  localparam int unsigned RELOAD_SEC_TENS = 5;
  localparam int unsigned RELOAD_DEFAULT  = 9;

  // Keypad codes above 9 are not valid BCD; saturate them to 9.
  function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load and a borrow out to the next digit.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int unsigned RELOAD = RELOAD_DEFAULT
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               dec,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  always_comb borrow_out = dec & (q == '0);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= (q == '0) ? DIGIT_W'(RELOAD) : q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS-style BCD countdown timer: keypad digit shift-in, prescaled one-second
// decrement, pause via enable, and a single-cycle done pulse on reaching zero.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 100
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [DIGIT_W-1:0]            data_in,
  input  logic                          loadn,
  input  logic                          start,
  input  logic                          enable,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic                          zero,
  output logic                          running,
  output logic                          done
);

  localparam int unsigned CNT_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t             state;
  state_t             next_state;
  logic [PRE_W-1:0]   pre;
  logic [PRE_W-1:0]   pre_next;
  logic               shift_c;
  logic               start_c;
  logic               tick_c;
  logic               finish_c;
  logic               count_is_one_c;
  logic [CNT_W-1:0]   shift_val_c;
  logic [NUM_DIGITS:0] dec_chain;

  always_comb begin
    count_is_one_c = (digits == CNT_W'(1));
    shift_val_c    = {digits[CNT_W-DIGIT_W-1:0], clamp_bcd(data_in)};
  end

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a borrow out of the top digit also stops the run as a guard.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_c) next_state = RUN;
      RUN:  if (finish_c || dec_chain[NUM_DIGITS]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode: shift, start, prescaler advance and decrement tick.
  always_comb begin
    shift_c  = 1'b0;
    start_c  = 1'b0;
    tick_c   = 1'b0;
    finish_c = 1'b0;
    pre_next = pre;
    case (state)
      IDLE: begin
        shift_c = !loadn;
        start_c = loadn && start && !zero;
        if (start_c) pre_next = '0;
      end
      RUN: begin
        if (enable) begin
          if (pre == PRE_W'(TICK_DIV - 1)) begin
            tick_c   = 1'b1;
            pre_next = '0;
          end else begin
            pre_next = pre + PRE_W'(1);
          end
        end
        finish_c = tick_c && count_is_one_c;
      end
      default: ;
    endcase
  end

  assign dec_chain[0] = tick_c;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned RELOAD_I =
      (i == SEC_TENS_IDX) ? RELOAD_SEC_TENS : RELOAD_DEFAULT;

    bcd_down_digit #(
      .RELOAD(RELOAD_I)
    ) u_digit (
      .clock     (clock),
      .clear     (clear),
      .dec       (dec_chain[i]),
      .load      (shift_c),
      .load_val  (shift_val_c[DIGIT_W*i +: DIGIT_W]),
      .q         (digits[DIGIT_W*i +: DIGIT_W]),
      .borrow_out(dec_chain[i+1])
    );
  end

  // Prescaler and registered status outputs, updated alongside the digits.
  always_ff @(posedge clock) begin
    if (clear) begin
      pre     <= '0;
      zero    <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      pre     <= pre_next;
      running <= (next_state == RUN);
      done    <= finish_c;
      if (shift_c) begin
        zero <= (shift_val_c == '0);
      end else if (finish_c) begin
        zero <= 1'b1;
      end
    end
  end

endmodule
